uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 135 +++++++++++++
 tb/tb_uart.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// UART: transmitter and 16x-oversampling receiver, both clocked by clk16x.
// Frame: start 0, d[0]..d[7] LSB first, odd parity, stop 1; 16 clk16x cycles per bit.
module uart (
    input  logic        clk16x,
    input  logic        clrn,
    input  logic        rdn,
    output logic [7:0]  d_out,
    output logic        r_ready,
    input  logic        rxd,
    output logic        parity_error,
    output logic        frame_error,
    input  logic        wrn,
    input  logic [7:0]  d_in,
    output logic        t_empty,
    output logic        txd,
    output logic [3:0]  cnt16x,
    output logic [3:0]  no_bits_rcvd,
    output logic [10:0] r_buffer,
    output logic        r_clk1x,
    output logic        sampling,
    output logic [7:0]  r_data,
    output logic [3:0]  no_bits_sent,
    output logic [7:0]  t_buffer,
    output logic        t_clk1x,
    output logic        sending,
    output logic [7:0]  t_data
);

    logic       wrn_q;
    logic       wr_pulse;
    logic       tx_load;
    logic [3:0] t_cnt16x;
    logic       rx_done;

    assign d_out    = r_data;
    assign wr_pulse = wrn_q & ~wrn;
    assign t_clk1x  = sending && (t_cnt16x == 4'd15);
    // A pending byte starts from idle, or exactly as the previous stop bit ends.
    assign tx_load  = !t_empty && (!sending || (t_clk1x && no_bits_sent == 4'd10));
    assign r_clk1x  = sampling && (cnt16x == 4'd7);

    always_ff @(posedge clk16x) begin
        if (!clrn) begin
            wrn_q        <= 1'b1;
            t_data       <= '0;
            t_empty      <= 1'b1;
            t_buffer     <= '0;
            sending      <= 1'b0;
            no_bits_sent <= '0;
            t_cnt16x     <= '0;
            txd          <= 1'b1;
        end else begin
            wrn_q <= wrn;
            if (tx_load) begin
                t_buffer     <= t_data;
                t_empty      <= 1'b1;
                sending      <= 1'b1;
                no_bits_sent <= '0;
                t_cnt16x     <= '0;
                txd          <= 1'b0;
            end else if (sending) begin
                t_cnt16x <= t_cnt16x + 4'd1;
                if (t_clk1x) begin
                    if (no_bits_sent == 4'd10) begin
                        sending      <= 1'b0;
                        no_bits_sent <= '0;
                        txd          <= 1'b1;
                    end else begin
                        no_bits_sent <= no_bits_sent + 4'd1;
                        if (no_bits_sent <= 4'd7)
                            txd <= t_buffer[no_bits_sent[2:0]];
                        else if (no_bits_sent == 4'd8)
                            txd <= ~^t_buffer;
                        else
                            txd <= 1'b1;
                    end
                end
            end
            // NOTE: non-blocking, last assignment wins: a write in the load cycle keeps t_empty=0.
            if (wr_pulse) begin
                t_data  <= d_in;
                t_empty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk16x) begin
        if (!clrn) begin
            r_ready      <= 1'b0;
            r_data       <= '0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            r_buffer     <= '0;
            sampling     <= 1'b0;
            cnt16x       <= '0;
            no_bits_rcvd <= '0;
            rx_done      <= 1'b0;
        end else begin
            if (!rdn)
                r_ready <= 1'b0;
            if (rx_done) begin
                // Completion overrides a same-cycle read strobe.
                r_data       <= r_buffer[8:1];
                parity_error <= ~^r_buffer[9:1];
                frame_error  <= ~r_buffer[10];
                r_ready      <= 1'b1;
                sampling     <= 1'b0;
                cnt16x       <= '0;
                no_bits_rcvd <= '0;
                rx_done      <= 1'b0;
            end else if (!sampling) begin
                if (!rxd) begin
                    sampling     <= 1'b1;
                    cnt16x       <= '0;
                    no_bits_rcvd <= '0;
                end
            end else begin
                cnt16x <= cnt16x + 4'd1;
                if (r_clk1x) begin
                    if (no_bits_rcvd == 4'd0 && rxd) begin
                        sampling <= 1'b0;
                        cnt16x   <= '0;
                    end else begin
                        r_buffer <= {rxd, r_buffer[10:1]};
                        if (no_bits_rcvd == 4'd10)
                            rx_done <= 1'b1;
                        else
                            no_bits_rcvd <= no_bits_rcvd + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: table-driven receive vectors, loopback and
// randomized frames checked against a bit-level frame model.
module tb_uart;

    logic        clk16x;
    logic        clrn;
    logic        rdn;
    logic [7:0]  d_out;
    logic        r_ready;
    logic        rxd;
    logic        parity_error;
    logic        frame_error;
    logic        wrn;
    logic [7:0]  d_in;
    logic        t_empty;
    logic        txd;
    logic [3:0]  cnt16x;
    logic [3:0]  no_bits_rcvd;
    logic [10:0] r_buffer;
    logic        r_clk1x;
    logic        sampling;
    logic [7:0]  r_data;
    logic [3:0]  no_bits_sent;
    logic [7:0]  t_buffer;
    logic        t_clk1x;
    logic        sending;
    logic [7:0]  t_data;

    logic loop, auto_ack, man_rdn, ack_q, rxd_drv, prev_rdy;
    int   checks, failures, run;
    logic [9:0] rx_q[$];
    int         len_q[$];

    typedef struct packed {
        logic [7:0] data;
        logic       flip_par;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } rx_vec_t;
    rx_vec_t vecs[5];

    assign rxd = loop ? txd : rxd_drv;
    assign rdn = auto_ack ? ack_q : man_rdn;

    uart dut (
        .clk16x(clk16x), .clrn(clrn), .rdn(rdn), .d_out(d_out), .r_ready(r_ready),
        .rxd(rxd), .parity_error(parity_error), .frame_error(frame_error),
        .wrn(wrn), .d_in(d_in), .t_empty(t_empty), .txd(txd), .cnt16x(cnt16x),
        .no_bits_rcvd(no_bits_rcvd), .r_buffer(r_buffer), .r_clk1x(r_clk1x),
        .sampling(sampling), .r_data(r_data), .no_bits_sent(no_bits_sent),
        .t_buffer(t_buffer), .t_clk1x(t_clk1x), .sending(sending), .t_data(t_data)
    );

    initial begin
        clk16x = 1'b0;
        forever #5 clk16x = ~clk16x;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Records every received byte and the length of each r_ready pulse.
    initial begin
        prev_rdy = 1'b0;
        ack_q    = 1'b1;
        run      = 0;
        forever begin
            @(negedge clk16x);
            if (r_ready && !prev_rdy)
                rx_q.push_back({frame_error, parity_error, d_out});
            if (r_ready)
                run++;
            else if (prev_rdy) begin
                len_q.push_back(run);
                run = 0;
            end
            prev_rdy = r_ready;
            ack_q    = !r_ready;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmission order in bit k: start, data LSB first, parity making the ones count odd, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk16x);
    endtask

    task automatic write_byte(input logic [7:0] b);
        d_in = b;
        wrn  = 1'b0;
        @(negedge clk16x);
        wrn  = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f);
        for (int k = 0; k < 11; k++) begin
            rxd_drv = f[k];
            tick(16);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic capture_frame(input logic [7:0] b, input int budget, input string tag);
        logic [10:0] exp;
        logic [15:0] seg;
        logic        seen;
        int          n;
        exp  = model_frame(b);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk16x);
            n++;
            if (txd == 1'b0) seen = 1'b1;
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (!seen) return;
        for (int k = 0; k < 11; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (k != 0 || j != 0) @(negedge clk16x);
                seg[j] = txd;
            end
            check($sformatf("%s_bit%0d", tag, k), 32'(seg), 32'({16{exp[k]}}));
        end
    endtask

    task automatic expect_rx(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        check({tag, "_cnt"}, 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic check_lens(input string tag, input int n);
        check({tag, "_npulse"}, 32'(len_q.size()), 32'(n));
        while (len_q.size() > 0) begin
            int l;
            l = len_q.pop_front();
            check({tag, "_pulse_len"}, 32'(l), 32'd1);
        end
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        logic        bad;

        checks   = 0;
        failures = 0;
        clrn     = 1'b0;
        wrn      = 1'b1;
        d_in     = '0;
        rxd_drv  = 1'b1;
        man_rdn  = 1'b1;
        loop     = 1'b0;
        auto_ack = 1'b0;

        vecs[0] = '{data: 8'hA5, flip_par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h3C, flip_par: 1'b1, stop: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
        vecs[2] = '{data: 8'h00, flip_par: 1'b0, stop: 1'b0, exp_pe: 1'b0, exp_fe: 1'b1};
        vecs[3] = '{data: 8'hFF, flip_par: 1'b1, stop: 1'b0, exp_pe: 1'b1, exp_fe: 1'b1};
        vecs[4] = '{data: 8'h81, flip_par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};

        // Reset state
        tick(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_t_empty", 32'(t_empty), 32'd1);
        check("rst_r_ready", 32'(r_ready), 32'd0);
        check("rst_sending", 32'(sending), 32'd0);
        check("rst_sampling", 32'(sampling), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_errors", 32'({parity_error, frame_error}), 32'd0);
        check("rst_counters", 32'({cnt16x, no_bits_rcvd, no_bits_sent}), 32'd0);
        check("rst_buffers", 32'({r_buffer, t_buffer, t_data}), 32'd0);
        clrn = 1'b1;
        tick(2);

        // Loopback: two writes two cycles apart, frames back-to-back, auto acknowledge
        loop     = 1'b1;
        auto_ack = 1'b1;
        rx_q.delete();
        len_q.delete();
        fork
            begin
                write_byte(8'hE1);
                tick(1);
                write_byte(8'h55);
            end
            begin
                capture_frame(8'hE1, 40, "lb0");
                capture_frame(8'h55, 1, "lb1");
            end
        join
        @(negedge clk16x);
        check("lb_idle_txd", 32'(txd), 32'd1);
        check("lb_idle_sending", 32'(sending), 32'd0);
        tick(10);
        expect_rx("lb_rx0", {2'b00, 8'hE1});
        expect_rx("lb_rx1", {2'b00, 8'h55});
        check_lens("lb", 2);

        // Random bytes through the loopback
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            rx_q.delete();
            len_q.delete();
            write_byte(b);
            capture_frame(b, 40, $sformatf("rtx%0d", i));
            tick(20);
            expect_rx($sformatf("rtx%0d_rx", i), {2'b00, b});
            check_lens($sformatf("rtx%0d", i), 1);
        end

        // Random injected frames, some with a corrupted parity bit
        loop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            f   = model_frame(b);
            if (bad) f[9] = ~f[9];
            rx_q.delete();
            send_frame(f);
            tick($urandom_range(2, 12));
            expect_rx($sformatf("rrx%0d", i), {1'b0, bad, b});
        end

        // Table of injected frames with manual acknowledge
        auto_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f     = model_frame(vecs[i].data);
            f[9]  = f[9] ^ vecs[i].flip_par;
            f[10] = vecs[i].stop;
            send_frame(f);
            tick(24);
            check($sformatf("vec%0d_ready", i), 32'(r_ready), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(d_out), 32'(vecs[i].data));
            check($sformatf("vec%0d_pe", i), 32'(parity_error), 32'(vecs[i].exp_pe));
            check($sformatf("vec%0d_fe", i), 32'(frame_error), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_idle", i), 32'(sampling), 32'd0);
            man_rdn = 1'b0;
            @(negedge clk16x);
            man_rdn = 1'b1;
            check($sformatf("vec%0d_ack", i), 32'(r_ready), 32'd0);
        end

        // Overrun: second frame overwrites the unread first one
        send_frame(model_frame(8'h12));
        send_frame(model_frame(8'h34));
        tick(4);
        check("ovr_ready", 32'(r_ready), 32'd1);
        check("ovr_data", 32'(d_out), 32'h34);

        // Read strobe held low across a completion: r_ready still rises
        man_rdn = 1'b0;
        tick(2);
        rx_q.delete();
        send_frame(model_frame(8'h5A));
        tick(4);
        man_rdn = 1'b1;
        expect_rx("rdn_same", {2'b00, 8'h5A});
        check("rdn_same_cleared", 32'(r_ready), 32'd0);

        // False start: 4-cycle low pulse
        rx_q.delete();
        rxd_drv = 1'b0;
        tick(3);
        check("fs_sampling", 32'(sampling), 32'd1);
        tick(1);
        rxd_drv = 1'b1;
        tick(30);
        check("fs_idle", 32'(sampling), 32'd0);
        check("fs_no_rx", 32'(rx_q.size()), 32'd0);
        check("fs_ready", 32'(r_ready), 32'd0);

        // Reset in the middle of a frame, then a clean frame
        loop = 1'b1;
        write_byte(8'hC3);
        capture_frame(8'hC3, 40, "pre");
        tick(20);
        check("pre_ready", 32'(r_ready), 32'd1);
        write_byte(8'h96);
        tick(60);
        clrn = 1'b0;
        @(negedge clk16x);
        clrn = 1'b1;
        check("mr_txd", 32'(txd), 32'd1);
        check("mr_t_empty", 32'(t_empty), 32'd1);
        check("mr_r_ready", 32'(r_ready), 32'd0);
        check("mr_busy", 32'({sending, sampling}), 32'd0);
        check("mr_data", 32'({d_out, t_data}), 32'd0);
        write_byte(8'h3A);
        capture_frame(8'h3A, 40, "post");
        tick(20);
        check("post_ready", 32'(r_ready), 32'd1);
        check("post_data", 32'(d_out), 32'h3A);
        check("post_errors", 32'({parity_error, frame_error}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
